// File: rtl/dslave_wr_arbiter_if.sv
// Requester-side and Avalon-MM write-side signals of the write arbiter, bundled.
// Handshake: a transfer completes in any cycle with avm_m0_write=1 and avm_m0_waitrequest=0; ack_o pulses to the owner in that same cycle.
interface dslave_wr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int CW    = 16
);
    logic [N_REQ-1:0]    req_i;
    logic [N_REQ*DW-1:0] data_i;
    logic [N_REQ-1:0]    grant_o;
    logic [N_REQ-1:0]    ack_o;
    logic                avm_m0_write;
    logic [DW-1:0]       avm_m0_writedata;
    logic                avm_m0_waitrequest;
    logic [CW-1:0]       wr_count_o;
    logic                dbg_state;

    modport master (
        input  req_i, data_i, avm_m0_waitrequest,
        output grant_o, ack_o, avm_m0_write, avm_m0_writedata, wr_count_o, dbg_state
    );

    modport slave (
        output req_i, data_i, avm_m0_waitrequest,
        input  grant_o, ack_o, avm_m0_write, avm_m0_writedata, wr_count_o, dbg_state
    );
endinterface

// File: rtl/dslave_wr_arbiter.sv
// Round-robin write arbiter with per-owner hold limit driving one Avalon-MM write slave.
// One write in flight at a time; accepted writes are counted modulo 2^CW.
module dslave_wr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4,
    parameter int CW       = 16
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset_n,
    dslave_wr_arbiter_if.master   bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [CW-1:0]   cnt_q;
    logic            wr_active;
    logic            accept;
    logic            keep;
    logic            rr_found;
    logic [IW-1:0]   rr_pick;
    logic [IW-1:0]   cand;

    // First requester after the previous owner, wrapping; the previous owner itself is scanned last.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        cand     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(last_q) + i) % N_REQ);
            if (!rr_found && bus.req_i[cand]) begin
                rr_found = 1'b1;
                rr_pick  = cand;
            end
        end
    end

    // hold_q == 0 only straight after reset, when no one owns the slave yet.
    assign keep = (hold_q != '0) && (int'(hold_q) < MAX_HOLD) && bus.req_i[last_q];

    assign wr_active = (state_q == WRITE);
    assign accept    = wr_active && !bus.avm_m0_waitrequest;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_i) begin
                    state_d = WRITE;
                    if (keep) begin
                        owner_d = last_q;
                        hold_d  = hold_q + HW'(1);
                    end else begin
                        owner_d = rr_pick;
                        hold_d  = HW'(1);
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            if (accept) cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bus.avm_m0_write     = wr_active;
    assign bus.grant_o          = wr_active ? (N_REQ'(1) << owner_q) : '0;
    assign bus.ack_o            = accept ? (N_REQ'(1) << owner_q) : '0;
    assign bus.avm_m0_writedata = wr_active ? bus.data_i[int'(owner_q)*DW +: DW] : '0;
    assign bus.wr_count_o       = cnt_q;
    assign bus.dbg_state        = state_q;
endmodule

// File: tb/tb_dslave_wr_arbiter.sv
// Bench for dslave_wr_arbiter: cycle vectors, round-robin instance, and scoreboarded write sequences.
module tb_dslave_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;

    logic csi_clk = 1'b0;
    logic rsi_reset_n = 1'b0;
    always #5 csi_clk = ~csi_clk;

    dslave_wr_arbiter_if #(.N_REQ(N), .DW(DW), .CW(CW)) m_if ();
    dslave_wr_arbiter_if #(.N_REQ(N), .DW(DW), .CW(16)) r_if ();

    dslave_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_HOLD(4), .CW(CW)) u_dut (
        .csi_clk     (csi_clk),
        .rsi_reset_n (rsi_reset_n),
        .bus         (m_if.master)
    );

    dslave_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_HOLD(1), .CW(16)) u_rr (
        .csi_clk     (csi_clk),
        .rsi_reset_n (rsi_reset_n),
        .bus         (r_if.master)
    );

    typedef struct {
        logic [3:0] req;
        logic [7:0] d2;
        logic       wr;
        logic       e_write;
        logic [3:0] e_grant;
        logic [3:0] e_ack;
        logic [7:0] e_wdata;
        logic [3:0] e_cnt;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ack_seen = 0;
    int          last_ack_cyc = 0;
    int          last_gap = 0;
    bit          sb_on = 1'b0;
    logic [3:0]  sb_cnt = '0;
    logic [11:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge csi_clk);
        cyc = cyc + 1;
    end

    // Scoreboard: each accepted write pops one {onehot owner, data} record.
    initial forever begin
        logic [11:0] e;
        @(negedge csi_clk);
        if (sb_on && rsi_reset_n && (m_if.ack_o != '0)) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_ack", 32'(m_if.ack_o), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("sb_ack", 32'(m_if.ack_o), 32'(e[11:8]));
                check("sb_grant", 32'(m_if.grant_o), 32'(e[11:8]));
                check("sb_wdata", 32'(m_if.avm_m0_writedata), 32'(e[7:0]));
                check("sb_count", 32'(m_if.wr_count_o), 32'(sb_cnt));
            end
            sb_cnt = sb_cnt + 4'd1;
            ack_seen = ack_seen + 1;
            last_gap = cyc - last_ack_cyc;
            last_ack_cyc = cyc;
        end
    end

    task automatic do_reset();
        rsi_reset_n = 1'b0;
        m_if.req_i = '0;
        m_if.data_i = '0;
        m_if.avm_m0_waitrequest = 1'b0;
        sb_cnt = '0;
        repeat (2) @(posedge csi_clk);
        #1 rsi_reset_n = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input int i);
        @(posedge csi_clk);
        #1;
        m_if.req_i = v.req;
        m_if.data_i = {8'h97, v.d2, 8'hB2, 8'hE1};
        m_if.avm_m0_waitrequest = v.wr;
        @(negedge csi_clk);
        check($sformatf("vec%0d_write", i), 32'(m_if.avm_m0_write), 32'(v.e_write));
        check($sformatf("vec%0d_state", i), 32'(m_if.dbg_state), 32'(v.e_write));
        check($sformatf("vec%0d_grant", i), 32'(m_if.grant_o), 32'(v.e_grant));
        check($sformatf("vec%0d_ack", i), 32'(m_if.ack_o), 32'(v.e_ack));
        check($sformatf("vec%0d_wdata", i), 32'(m_if.avm_m0_writedata), 32'(v.e_wdata));
        check($sformatf("vec%0d_count", i), 32'(m_if.wr_count_o), 32'(v.e_cnt));
    endtask

    // Holds req until n more writes are accepted, then drops it right after the last ack edge.
    task automatic run_writes(input logic [3:0] req, input int n, input bit chk_gap, input bit rand_stall);
        int start = ack_seen;
        int prev = ack_seen;
        int budget = n * 40 + 20;
        m_if.req_i = req;
        m_if.avm_m0_waitrequest = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
        while ((ack_seen < start + n) && (budget > 0)) begin
            @(posedge csi_clk);
            #1;
            budget--;
            m_if.avm_m0_waitrequest = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
            if (chk_gap && (ack_seen != prev)) begin
                if (prev != start) check("no_gap_spacing", 32'(last_gap), 32'd2);
                prev = ack_seen;
            end
        end
        check("writes_done", 32'(ack_seen - start), 32'(n));
        m_if.req_i = '0;
        m_if.avm_m0_waitrequest = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[13];
        logic [3:0] rr_exp_g[5];
        logic [7:0] rr_exp_d[5];
        logic [3:0] rr_got_g[5];
        logic [7:0] rr_got_d[5];
        int         nwr;
        logic [7:0] d0, d1, d;
        int         k, b;

        vecs[0]  = '{4'b0100, 8'h5A, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'd0};
        vecs[1]  = '{4'b0100, 8'h5A, 1'b0, 1'b1, 4'b0100, 4'b0100, 8'h5A, 4'd0};
        vecs[2]  = '{4'b0100, 8'h5A, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'd1};
        vecs[3]  = '{4'b0100, 8'h5A, 1'b0, 1'b1, 4'b0100, 4'b0100, 8'h5A, 4'd1};
        vecs[4]  = '{4'b0000, 8'h5A, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'd2};
        vecs[5]  = '{4'b0100, 8'hC3, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'd2};
        for (int i = 6; i <= 10; i++)
            vecs[i] = '{4'b0100, 8'hC3, 1'b1, 1'b1, 4'b0100, 4'b0000, 8'hC3, 4'd2};
        vecs[11] = '{4'b0100, 8'hC3, 1'b0, 1'b1, 4'b0100, 4'b0100, 8'hC3, 4'd2};
        vecs[12] = '{4'b0000, 8'hC3, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'd3};

        rr_exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        r_if.req_i = 4'hF;
        r_if.data_i = 32'h44332211;
        r_if.avm_m0_waitrequest = 1'b0;
        m_if.req_i = 4'b0100;
        m_if.data_i = 32'hFFFFFFFF;
        m_if.avm_m0_waitrequest = 1'b0;

        // Reset values while reset is held with requests present.
        #2;
        check("rst_write", 32'(m_if.avm_m0_write), 32'h0);
        check("rst_grant", 32'(m_if.grant_o), 32'h0);
        check("rst_ack", 32'(m_if.ack_o), 32'h0);
        check("rst_wdata", 32'(m_if.avm_m0_writedata), 32'h0);
        check("rst_count", 32'(m_if.wr_count_o), 32'h0);
        check("rst_rr_write", 32'(r_if.avm_m0_write), 32'h0);

        // Single requester, then a 5-cycle stall on requester 2.
        do_reset();
        for (int i = 0; i < 13; i++) apply_vec(vecs[i], i);

        // Round-robin with MAX_HOLD=1 on the second instance.
        do_reset();
        nwr = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge csi_clk);
            @(negedge csi_clk);
            if (r_if.avm_m0_write && nwr < 5) begin
                rr_got_g[nwr] = r_if.grant_o;
                rr_got_d[nwr] = r_if.avm_m0_writedata;
                check("rr_ack_eq_grant", 32'(r_if.ack_o), 32'(r_if.grant_o));
                nwr++;
            end
        end
        check("rr_nwrites", 32'(nwr), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < nwr) begin
                check($sformatf("rr_grant%0d", i), 32'(rr_got_g[i]), 32'(rr_exp_g[i]));
                check($sformatf("rr_data%0d", i), 32'(rr_got_d[i]), 32'(rr_exp_d[i]));
            end
        end
        check("rr_count", r_if.wr_count_o, 32'd5);

        // Hold limit with two requesters, then a lone requester back to back.
        do_reset();
        sb_on = 1'b1;
        d0 = 8'($urandom_range(0, 255));
        d1 = 8'($urandom_range(0, 255));
        m_if.data_i = {8'h00, 8'h00, d1, d0};
        for (int i = 0; i < 4; i++) exp_q.push_back({4'b0001, d0});
        for (int i = 0; i < 4; i++) exp_q.push_back({4'b0010, d1});
        for (int i = 0; i < 2; i++) exp_q.push_back({4'b0001, d0});
        run_writes(4'b0011, 10, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) exp_q.push_back({4'b0001, d0});
        run_writes(4'b0001, 6, 1'b1, 1'b0);

        // Counter wrap over 17 writes with random owners, data and stalls.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            k = $urandom_range(0, N - 1);
            d = 8'($urandom_range(0, 255));
            m_if.data_i[k*DW +: DW] = d;
            exp_q.push_back({4'(1 << k), d});
            run_writes(4'(1 << k), 1, 1'b0, 1'b1);
        end
        check("wrap_count", 32'(m_if.wr_count_o), 32'd1);

        // Reset between edges during a stalled write.
        m_if.data_i[2*DW +: DW] = 8'hC3;
        m_if.req_i = 4'b0100;
        m_if.avm_m0_waitrequest = 1'b1;
        b = 0;
        while (!m_if.avm_m0_write && b < 10) begin
            @(negedge csi_clk);
            b++;
        end
        check("abort_write_up", 32'(m_if.avm_m0_write), 32'h1);
        @(posedge csi_clk);
        @(negedge csi_clk);
        #2 rsi_reset_n = 1'b0;
        #1;
        check("abort_write", 32'(m_if.avm_m0_write), 32'h0);
        check("abort_grant", 32'(m_if.grant_o), 32'h0);
        check("abort_ack", 32'(m_if.ack_o), 32'h0);
        check("abort_count", 32'(m_if.wr_count_o), 32'h0);
        sb_cnt = '0;
        @(posedge csi_clk);
        #1;
        m_if.req_i = 4'b1000;
        m_if.avm_m0_waitrequest = 1'b0;
        m_if.data_i[3*DW +: DW] = 8'h7E;
        rsi_reset_n = 1'b1;
        exp_q.push_back({4'b1000, 8'h7E});
        run_writes(4'b1000, 1, 1'b0, 1'b0);
        check("post_reset_count", 32'(m_if.wr_count_o), 32'd1);

        repeat (2) @(posedge csi_clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
